// File: rtl/vga_sync_generator.sv
// VGA timing generator: pixel/line counters, phase FSMs, active-low syncs and frame tick.
// Define VGA_SYNC_DELAY_EN to delay VGA_HS/VGA_VS by one enabled cycle (colour pipeline alignment).
module vga_sync_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       pix_en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       display_active,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_DISPLAY - 1);
  localparam logic [9:0] H_FP_END  = 10'(H_DISPLAY + H_FRONT - 1);
  localparam logic [9:0] H_SY_END  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_DISPLAY - 1);
  localparam logic [9:0] V_FP_END  = 10'(V_DISPLAY + V_FRONT - 1);
  localparam logic [9:0] V_SY_END  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

  phase_t     h_state, v_state;
  logic       hsync, vsync;
  logic       h_wrap, v_wrap;
  logic [9:0] h_next, v_next;

  // Next-position values let registered outputs line up with the counters they accompany.
  always_comb begin
    h_wrap = (h_count == H_LAST);
    v_wrap = (v_count == V_LAST);
    h_next = h_wrap ? 10'd0 : h_count + 10'd1;
    v_next = v_count;
    if (h_wrap) v_next = v_wrap ? 10'd0 : v_count + 10'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_count        <= 10'd0;
      v_count        <= 10'd0;
      h_state        <= ACTIVE;
      v_state        <= ACTIVE;
      hsync          <= 1'b1;
      vsync          <= 1'b1;
      display_active <= 1'b1;
      frame_tick     <= 1'b0;
      frame_count    <= 8'd0;
    end else begin
      frame_tick <= 1'b0;
      if (pix_en) begin
        h_count        <= h_next;
        v_count        <= v_next;
        display_active <= (h_next < 10'(H_DISPLAY)) && (v_next < 10'(V_DISPLAY));

        case (h_state)
          ACTIVE: if (h_count == H_ACT_END) h_state <= FRONT;
          FRONT:  if (h_count == H_FP_END) begin
                    h_state <= SYNC;
                    hsync   <= 1'b0;
                  end
          SYNC:   if (h_count == H_SY_END) begin
                    h_state <= BACK;
                    hsync   <= 1'b1;
                  end
          BACK:   if (h_wrap) h_state <= ACTIVE;
        endcase

        // Vertical phase only moves at end of line.
        if (h_wrap) begin
          case (v_state)
            ACTIVE: if (v_count == V_ACT_END) v_state <= FRONT;
            FRONT:  if (v_count == V_FP_END) begin
                      v_state <= SYNC;
                      vsync   <= 1'b0;
                    end
            SYNC:   if (v_count == V_SY_END) begin
                      v_state <= BACK;
                      vsync   <= 1'b1;
                    end
            BACK:   if (v_wrap) v_state <= ACTIVE;
          endcase
        end

        if (h_wrap && v_count == V_ACT_END) begin
          frame_tick  <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (pix_en) begin
      VGA_HS <= hsync;
      VGA_VS <= vsync;
    end
  end
`else
  assign VGA_HS = hsync;
  assign VGA_VS = vsync;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator using shrunk timing parameters so many frames fit in a short run.
// Reference model tracks a linear pixel index within the frame and derives all outputs arithmetically.
module tb_vga_sync_generator;
  localparam int HD = 4, HF = 2, HSY = 2, HB = 2;
  localparam int VD = 4, VF = 1, VSY = 2, VB = 2;
  localparam int HT = HD + HF + HSY + HB;
  localparam int VT = VD + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] h_count, v_count;
  logic       VGA_HS, VGA_VS, display_active, frame_tick;
  logic [7:0] frame_count;

  vga_sync_generator #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .CLK(CLK), .RST(RST), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .display_active(display_active), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   passes = 0;
  int   pos = 0;
  int   prev_pos = 0;
  int   ticks = 0;
  logic tick_exp = 1'b0;

  function automatic logic hs_of(input int p);
    int h;
    h = p % HT;
    return !(h >= HD + HF && h < HD + HF + HSY);
  endfunction

  function automatic logic vs_of(input int p);
    int v;
    v = p / HT;
    return !(v >= VD + VF && v < VD + VF + VSY);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d (pos=%0d)", tag, obs, exp, pos);
  endtask

  task automatic model_reset();
    pos = 0;
    prev_pos = 0;
    ticks = 0;
    tick_exp = 1'b0;
  endtask

  task automatic model_step(input logic en);
    tick_exp = 1'b0;
    if (en) begin
      prev_pos = pos;
      pos = (pos + 1) % FRAME;
      if (pos == VD * HT) begin
        tick_exp = 1'b1;
        ticks++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".h"}, 32'(h_count), 32'(pos % HT));
    check({tag, ".v"}, 32'(v_count), 32'(pos / HT));
`ifdef VGA_SYNC_DELAY_EN
    check({tag, ".hs"}, 32'(VGA_HS), 32'(hs_of(prev_pos)));
    check({tag, ".vs"}, 32'(VGA_VS), 32'(vs_of(prev_pos)));
`else
    check({tag, ".hs"}, 32'(VGA_HS), 32'(hs_of(pos)));
    check({tag, ".vs"}, 32'(VGA_VS), 32'(vs_of(pos)));
`endif
    check({tag, ".da"}, 32'(display_active), 32'((pos % HT) < HD && (pos / HT) < VD));
    check({tag, ".tick"}, 32'(frame_tick), 32'(tick_exp));
    check({tag, ".fc"}, 32'(frame_count), 32'(ticks % 256));
  endtask

  task automatic cycle(input logic en, input string tag);
    pix_en = en;
    @(posedge CLK);
    model_step(en);
    @(negedge CLK);
    check_all(tag);
  endtask

  logic wrap_seen = 1'b0;
  int   tick_cycles = 0;

  initial begin
    model_reset();
    repeat (3) @(negedge CLK);
    check_all("reset");
    RST = 1'b0;

    // First enabled cycle after release must step h 0->1.
    cycle(1'b1, "first");

    // Two full frames at full rate.
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, "full");

    // Half rate: every value held across the disabled cycle, tick stays one cycle wide.
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b1, "half_on");
      if (frame_tick) tick_cycles++;
      cycle(1'b0, "half_off");
      if (frame_tick) tick_cycles++;
    end
    check("half_tick_cycles", 32'(tick_cycles), 32'd2);

    // Advance into the horizontal sync of the last vertical sync line, then reset asynchronously.
    for (int i = 0; i < FRAME && pos != (VD + VF + VSY - 1) * HT + HD + HF + 1; i++)
      cycle(1'b1, "seek");
    check("seek_reached", 32'(pos), 32'((VD + VF + VSY - 1) * HT + HD + HF + 1));
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge CLK);
    check_all("rst_hold");
    RST = 1'b0;
    cycle(1'b1, "post_rst");

    // Random enable until frame_count has wrapped through 256 ticks.
    for (int i = 0; i < 40000 && ticks < 258; i++) begin
      cycle(($urandom_range(0, 3) != 0), "rand");
      if (frame_tick && ticks == 256 && frame_count == 8'd0) wrap_seen = 1'b1;
    end
    check("fc_wrap_seen", 32'(wrap_seen), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
